// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown core.
package microwave_pkg;

  // One BCD digit (0..9 in normal operation).
  typedef logic [3:0] bcd_t;

  // Cook time as displayed: minutes, tens of seconds, ones of seconds.
  typedef struct packed {
    bcd_t min;
    bcd_t sec_two;
    bcd_t sec_one;
  } cook_time_t;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // One-second countdown step. Borrowing out of the tens digit reloads it
  // with 5 so minutes roll over to x:59, while a keyed 99 s simply counts
  // down through 98, 97, ... without ever needing normalisation.
  function automatic cook_time_t bcd_decrement(input cook_time_t t);
    cook_time_t r;
    r = t;
    if (t.sec_one != 4'd0) begin
      r.sec_one = t.sec_one - 4'd1;
    end else if (t.sec_two != 4'd0) begin
      r.sec_one = BCD_MAX;
      r.sec_two = t.sec_two - 4'd1;
    end else if (t.min != 4'd0) begin
      r.min     = t.min - 4'd1;
      r.sec_two = SEC_TENS_MAX;
      r.sec_one = BCD_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// Control/display bundle between the keypad front end, the countdown core
// and the seven-segment decoder stage.
//
// Handshake semantics: there is no ready/backpressure anywhere. keypad_valid,
// start and stop_clear are one-cycle strobes sampled on the rising clk edge
// where they are high; the core always accepts or deliberately ignores them
// in that same edge. door_closed is a level. All outputs are registered.
interface microwave_timer_if;
  import microwave_pkg::*;

  logic [3:0] keypad_digit;
  logic       keypad_valid;
  logic       start;
  logic       stop_clear;
  logic       door_closed;

  bcd_t       sec_one;
  bcd_t       sec_two;
  bcd_t       min;
  logic       mag_on;
  logic       done;
  logic [1:0] state_dbg;

  // Controller side: drives strobes, observes display and status.
  modport master (
    output keypad_digit, keypad_valid, start, stop_clear, door_closed,
    input  sec_one, sec_two, min, mag_on, done, state_dbg
  );

  // Countdown core side.
  modport slave (
    input  keypad_digit, keypad_valid, start, stop_clear, door_closed,
    output sec_one, sec_two, min, mag_on, done, state_dbg
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while enabled.
// The count is forced to 0 whenever enable is low so every (re)start of the
// countdown waits a full TICK_DIV cycles for its first tick.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Free-run 0..TICK_DIV-1 while enabled, otherwise hold at zero.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Countdown core of the microwave controller: keypad entry of a three-digit
// BCD cook time, once-per-second countdown while running, pause/resume on
// stop or door open, and a one-cycle done pulse when the time reaches 0:00.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  microwave_timer_if.slave  bus
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  cook_time_t time_q;
  cook_time_t time_d;
  cook_time_t time_dec;
  logic       mag_on_q;
  logic       done_q;
  logic       done_d;
  logic       tick;
  logic       presc_en;

  // Only count while running and not about to leave RUNNING because of a
  // stop or door event; this also makes stop win over a same-cycle tick.
  assign presc_en = (state_q == ST_RUNNING) && !bus.stop_clear && bus.door_closed;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (presc_en),
    .tick   (tick)
  );

  assign time_dec = bcd_decrement(time_q);

  // Next-state, digit update and completion detection, in strobe priority
  // order: stop_clear, door open, start, tick, keypad.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.stop_clear) begin
          time_d = '0;
        end else if (bus.start && bus.door_closed && (time_q != '0)) begin
          state_d = ST_RUNNING;
        end else if (bus.keypad_valid && (bus.keypad_digit <= BCD_MAX)) begin
          time_d = '{min: time_q.sec_two, sec_two: time_q.sec_one,
                     sec_one: bus.keypad_digit};
        end
      end
      ST_RUNNING: begin
        if (bus.stop_clear || !bus.door_closed) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          time_d = time_dec;
          if (time_dec == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (bus.stop_clear) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (bus.start && bus.door_closed) begin
          state_d = ST_RUNNING;
        end
      end
      default: begin
        state_d = ST_IDLE;
        time_d  = '0;
      end
    endcase
  end

  // State, digits and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      time_q   <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      mag_on_q <= (state_d == ST_RUNNING);
      done_q   <= done_d;
    end
  end

  assign bus.sec_one   = time_q.sec_one;
  assign bus.sec_two   = time_q.sec_two;
  assign bus.min       = time_q.min;
  assign bus.mag_on    = mag_on_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICK_DIV=4.
module tb_microwave_timer;
  import microwave_pkg::*;

  localparam int TD = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [11:0] exp_q[$];
  logic [11:0] exp_v;

  microwave_timer_if bus ();

  microwave_timer #(
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock/reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after
  // the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    bus.keypad_digit = d;
    bus.keypad_valid = 1'b1;
    step(1);
    bus.keypad_valid = 1'b0;
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    key(a);
    key(b);
    key(c);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop_clear = 1'b1;
    step(1);
    bus.stop_clear = 1'b0;
  endtask

  // Scoreboard checks.
  task automatic check_time(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.min, bus.sec_two, bus.sec_one};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    checks++;
    assert (bus.state_dbg === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, bus.state_dbg, exp);
    end
  endtask

  task automatic check_next(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=empty expected=queued value", tag);
    end else begin
      exp_v = exp_q.pop_front();
      check_time(tag, exp_v);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.keypad_digit = 4'd0;
    bus.keypad_valid = 1'b0;
    bus.start        = 1'b0;
    bus.stop_clear   = 1'b0;
    bus.door_closed  = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    check_time ("reset_digits", 12'h000);
    check_bit  ("reset_mag", bus.mag_on, 1'b0);
    check_bit  ("reset_done", bus.done, 1'b0);
    check_state("reset_state", ST_IDLE);

    // 1. Keypad entry, invalid digit, clear.
    key(4'd1);
    check_time("key1", 12'h001);
    key(4'd2);
    key(4'd3);
    check_time("key123", 12'h123);
    check_bit ("key_mag", bus.mag_on, 1'b0);
    key(4'd12);
    check_time("key_invalid", 12'h123);
    pulse_stop();
    check_time("idle_clear", 12'h000);

    // 2. Basic countdown from 0:12.
    enter(4'd0, 4'd1, 4'd2);
    pulse_start();
    check_bit  ("run_mag", bus.mag_on, 1'b1);
    check_state("run_state", ST_RUNNING);
    step(3);
    check_time("before_first_tick", 12'h012);
    exp_q.push_back(12'h011);
    exp_q.push_back(12'h008);
    step(1);
    check_next("first_dec");
    step(12);
    check_next("after_12");
    pulse_stop();
    check_state("stop_to_paused", ST_PAUSED);
    pulse_stop();
    check_time("clear_after_pause", 12'h000);

    // 3. Minute and tens borrows.
    enter(4'd1, 4'd0, 4'd0);
    pulse_start();
    exp_q.push_back(12'h059);
    exp_q.push_back(12'h058);
    step(TD);
    check_next("borrow_min");
    step(TD);
    check_next("after_059");
    pulse_stop();
    pulse_stop();
    enter(4'd0, 4'd1, 4'd0);
    pulse_start();
    step(TD);
    check_time("borrow_tens", 12'h009);
    pulse_stop();
    pulse_stop();

    // 4. Completion and done pulse.
    enter(4'd0, 4'd0, 4'd2);
    pulse_start();
    step(TD);
    check_time("done_001", 12'h001);
    check_bit ("done_early", bus.done, 1'b0);
    step(TD - 1);
    check_time("done_hold", 12'h001);
    step(1);
    check_time ("done_000", 12'h000);
    check_bit  ("done_pulse", bus.done, 1'b1);
    check_bit  ("done_mag", bus.mag_on, 1'b0);
    check_state("done_idle", ST_IDLE);
    step(1);
    check_bit("done_one_cycle", bus.done, 1'b0);

    // 5. Door open pause, resume timing, stop/clear.
    enter(4'd0, 4'd0, 4'd5);
    pulse_start();
    step(2);
    bus.door_closed = 1'b0;
    step(1);
    check_state("door_paused", ST_PAUSED);
    check_bit  ("door_mag", bus.mag_on, 1'b0);
    step(20);
    check_time ("door_frozen", 12'h005);
    pulse_start();
    check_state("door_open_start", ST_PAUSED);
    bus.door_closed = 1'b1;
    pulse_start();
    check_bit("resume_mag", bus.mag_on, 1'b1);
    step(TD - 1);
    check_time("resume_full_second", 12'h005);
    step(1);
    check_time("resume_dec", 12'h004);
    pulse_stop();
    check_state("stop1_paused", ST_PAUSED);
    check_time ("stop1_kept", 12'h004);
    pulse_stop();
    check_state("stop2_idle", ST_IDLE);
    check_time ("stop2_zero", 12'h000);

    // Tick and stop in the same cycle: stop wins, no decrement.
    enter(4'd0, 4'd0, 4'd5);
    pulse_start();
    step(TD - 1);
    pulse_stop();
    check_time ("tick_stop_nodec", 12'h005);
    check_state("tick_stop_paused", ST_PAUSED);
    pulse_stop();

    // 6. Ignored starts, start+clear, keypad while running, reset mid-run.
    pulse_start();
    check_state("start_zero", ST_IDLE);
    check_bit  ("start_zero_mag", bus.mag_on, 1'b0);
    enter(4'd0, 4'd0, 4'd7);
    bus.door_closed = 1'b0;
    pulse_start();
    check_state("start_door_open", ST_IDLE);
    bus.door_closed = 1'b1;
    bus.start      = 1'b1;
    bus.stop_clear = 1'b1;
    step(1);
    bus.start      = 1'b0;
    bus.stop_clear = 1'b0;
    check_state("start_clear_idle", ST_IDLE);
    check_time ("start_clear_zero", 12'h000);
    enter(4'd0, 4'd0, 4'd7);
    pulse_start();
    key(4'd9);
    check_time("key_ignored_run", 12'h007);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_time ("midrun_reset_zero", 12'h000);
    check_state("midrun_reset_idle", ST_IDLE);
    check_bit  ("midrun_reset_mag", bus.mag_on, 1'b0);
    check_bit  ("midrun_reset_done", bus.done, 1'b0);
    step(1);
    check_bit("midrun_reset_done2", bus.done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Sequential countdown core of the microwave controller.
- Accepts keypad digits, holds the cook time as three BCD digits (min, sec_two, sec_one) and counts down once per second while the magnetron is enabled.
- Drives the BCD inputs of the downstream seven-segment decoder stage directly, plus magnetron enable and a completion pulse.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s decrement (benches use 4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
keypad_digit  in  4  BCD digit from keypad
keypad_valid  in  1  one-cycle strobe qualifying keypad_digit
start  in  1  start/resume strobe
stop_clear  in  1  stop (running) / clear (paused or idle) strobe
door_closed  in  1  level, 1 = door closed
sec_one  out  4  BCD ones of seconds, to decoder
sec_two  out  4  BCD tens of seconds, to decoder
min  out  4  BCD minutes, to decoder
mag_on  out  1  magnetron enable, high only in RUNNING
done  out  1  one-cycle pulse on countdown reaching 000

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, all digits 0, mag_on 0, done 0, prescaler 0.
- States:
  - IDLE: entry and clear.
  - RUNNING: countdown.
  - PAUSED: stopped or door opened, time retained.
- Priority when strobes coincide: reset > stop_clear > door open > start > tick > keypad.
- IDLE:
  - keypad_valid with digit <= 9 shifts left: min<=sec_two, sec_two<=sec_one, sec_one<=digit. Digits 10-15 are ignored.
  - Any digit <= 9 is accepted at every position, so an entry of 99 s is legal.
  - stop_clear zeroes all digits.
  - start with door_closed=1 and time != 000 -> RUNNING. start is ignored otherwise.
- RUNNING:
  - Prescaler counts 0..TICK_DIV-1. On wrap, one decrement is applied, so the first decrement lands TICK_DIV cycles after entering RUNNING.
  - stop_clear -> PAUSED.
  - door_closed=0 -> PAUSED.
  - keypad_valid is ignored.
- Decrement rule:
  - sec_one>0: sec_one-1.
  - Else sec_two>0: sec_one<=9, sec_two-1.
  - Else min>0: min-1, sec_two<=5, sec_one<=9.
- Completion: the decrement that yields 000 moves to IDLE in the same edge. done is high for exactly the first cycle where digits read 000 in IDLE.
- PAUSED:
  - start with door_closed=1 -> RUNNING, digits kept.
  - stop_clear -> IDLE, digits zeroed.
  - keypad_valid is ignored.
- Prescaler is held at 0 whenever the state is not RUNNING, so resume restarts a full second.
- mag_on is registered: it is 1 exactly in cycles where state==RUNNING.
- Outputs are always valid BCD (0..9) and are registered with no combinational path from inputs.
- Reset mid-countdown returns to IDLE/000 on the next edge with no done pulse.
- tick and stop_clear in the same cycle: stop wins, no decrement.

Decomposition:
- Shared package microwave_pkg:
  - state encoding (IDLE, RUNNING, PAUSED)
  - BCD_MAX=9
  - SEC_TENS_MAX=5
  - 4-bit BCD digit type
- Sub-module tick_prescaler:
  - inputs: clk, reset, enable; parameter TICK_DIV
  - output: one-cycle tick
  - count cleared when enable=0

Test Plan (TICK_DIV=4):
1. Reset, key 1,2,3 strobes -> min=1, sec_two=2, sec_one=3, mag_on=0. Key 12 -> no change. stop_clear -> 000.
2. Enter 012, door_closed=1, start -> mag_on=1 next cycle. After 4 cycles digits 011. After 12 more cycles 008.
3. Enter 100, start -> first decrement gives 059, next 058. Enter 010, start -> 009.
4. Enter 002, start -> 001 then 000 after 8 cycles total. done high exactly 1 cycle, mag_on=0, state IDLE.
5. Running 005, door_closed=0 -> PAUSED, mag_on=0, digits frozen for 20 cycles. Door closed and start -> resumes, next decrement exactly 4 cycles later. stop_clear twice -> PAUSED then IDLE/000.
6. Start with 000 or door open -> stays IDLE. start+stop_clear same cycle -> stays IDLE. reset mid-run -> 000, no done.
